// File: rtl/divider_control.sv
// divider_control: sequencing FSM for a 32-cycle restoring divider.
//
// Drives an external datapath that holds the operand magnitudes
// (dividend_reg, divisor_reg) and the partial remainder (R_reg).
//   clk, rst              rising-edge clock, asynchronous active-low reset
//   start                 request pulse, only honoured in IDLE
//   div_op                div / divu / rem / remu
//   dividend, divisor     raw RS1 / RS2, held stable while busy
//   dividend_reg, divisor_reg, R_reg   datapath registers fed back
//   counter               current quotient bit index (31..0)
//   compute_sign, flip_dividend, flip_divisor   magnitude capture
//   compute_start, shift_signal, sub_shift      iteration controls
//   special_zero, divide_by_zero, overflow      shortcut-result loads
//   busy, done            status
//
// Build option: define DIV_EARLY_TERM_EN to add the early-termination
// shortcut (dividend magnitude < divisor magnitude gives a zero quotient).

package divider_control_pkg;
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mult_funct3_t;
endpackage

module divider_control
  import divider_control_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  mult_funct3_t div_op,
  input  logic [31:0]  dividend,
  input  logic [31:0]  divisor,
  input  logic [31:0]  dividend_reg,
  input  logic [31:0]  divisor_reg,
  input  logic [31:0]  R_reg,
  output logic [31:0]  counter,
  output logic         compute_sign,
  output logic         flip_dividend,
  output logic         flip_divisor,
  output logic         compute_start,
  output logic         shift_signal,
  output logic         sub_shift,
  output logic         special_zero,
  output logic         divide_by_zero,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE,
    SIGN,
    CHECK,
    SHIFT,
    COMPARE,
    DONE
  } state_t;

  state_t state;

  logic signed_op;
  logic is_zero;
  logic is_ovf;
  logic is_small;

  assign signed_op = (div_op == DIV) || (div_op == REM);
  assign is_zero   = (divisor == '0);
  assign is_ovf    = signed_op && (dividend == 32'h8000_0000) && (divisor == '1);

`ifdef DIV_EARLY_TERM_EN
  // Magnitudes were captured at the end of SIGN, so they are valid in CHECK.
  assign is_small = (dividend_reg < divisor_reg);
`else
  logic unused_dividend_reg;
  assign unused_dividend_reg = ^dividend_reg;
  assign is_small = 1'b0;
`endif

  // Outputs decode the state register (plus held operands / datapath
  // feedback); start never reaches an output combinationally.
  always_comb begin
    compute_sign   = (state == SIGN);
    flip_dividend  = compute_sign && signed_op && dividend[31];
    flip_divisor   = compute_sign && signed_op && divisor[31];
    divide_by_zero = (state == CHECK) && is_zero;
    overflow       = (state == CHECK) && !is_zero && is_ovf;
    special_zero   = (state == CHECK) && !is_zero && !is_ovf && is_small;
    compute_start  = (state == CHECK) && !is_zero && !is_ovf && !is_small;
    shift_signal   = (state == SHIFT);
    sub_shift      = (state == COMPARE) && (R_reg >= divisor_reg);
  end

  // busy/done are registered alongside the state so they reflect the
  // state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      counter <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SIGN;
          end else begin
            busy <= 1'b0;
          end
        end
        SIGN: begin
          state <= CHECK;
        end
        CHECK: begin
          if (compute_start) begin
            state   <= SHIFT;
            counter <= 32'd31;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        SHIFT: begin
          state <= COMPARE;
        end
        COMPARE: begin
          if (counter == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state   <= SHIFT;
            counter <= counter - 32'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/divider_control.md
DIVIDER_CONTROL -- requirements
Module: divider_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
REQ-002 The block SHALL have these inputs:
- start  in  1  request pulse; sampled only in IDLE
- div_op  in  mult_funct3_t  div, divu, rem, remu
- dividend  in  32  RS1, held stable while busy
- divisor  in  32  RS2, held stable while busy
- dividend_reg, divisor_reg, R_reg  in  32 each  datapath magnitude and remainder registers
REQ-003 The block SHALL have these datapath-control outputs:
- counter  out  32  current bit index, 31..0
- compute_sign, flip_dividend, flip_divisor  out  1 each  magnitude-capture controls
- compute_start, shift_signal, sub_shift  out  1 each  iteration controls
- special_zero, divide_by_zero, overflow  out  1 each  shortcut-result loads
REQ-004 The block SHALL have these status outputs:
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle result-valid pulse

Function
REQ-005 The FSM SHALL have exactly these states: IDLE, SIGN, CHECK, SHIFT, COMPARE, DONE.
REQ-006 In IDLE, a start high at a rising edge SHALL move the FSM to SIGN; start in any other state SHALL be ignored.
REQ-007 SIGN SHALL last 1 cycle and assert compute_sign.
- div/rem: flip_dividend = dividend[31], flip_divisor = divisor[31].
- divu/remu: both flips = 0.
- Next state: CHECK.
REQ-008 CHECK SHALL last 1 cycle and evaluate in priority order:
- divisor == 0: assert divide_by_zero, go to DONE.
- signed op, dividend == 0x80000000 and divisor == 0xFFFFFFFF: assert overflow, go to DONE.
- otherwise: assert compute_start, load counter = 31, go to SHIFT.
REQ-009 SHIFT SHALL assert shift_signal for 1 cycle, then go to COMPARE.
REQ-010 COMPARE SHALL assert sub_shift when R_reg >= divisor_reg (32-bit unsigned compare); counter SHALL hold its value through COMPARE.
REQ-011 On leaving COMPARE: if counter == 0, go to DONE; otherwise decrement counter and go to SHIFT.
REQ-012 DONE SHALL assert done for exactly 1 cycle, then return to IDLE; done SHALL be low in every other state.
REQ-013 Normal-path latency: start sampled at edge 0 gives SIGN in cycle 1, CHECK in cycle 2, 32 SHIFT/COMPARE pairs in cycles 3-66, and done in cycle 67.
REQ-014 Shortcut-path latency: divide_by_zero, overflow or special_zero in cycle 2 gives done in cycle 3.
REQ-015 Mutual exclusion: at most one of compute_sign, compute_start, shift_signal, sub_shift, special_zero, divide_by_zero, overflow SHALL be high in any cycle.
REQ-016 All control outputs SHALL be registered-state decodes, with no combinational path from start to any output.

Reset
REQ-017 While rst is low, the FSM SHALL be in IDLE, counter = 0, and every 1-bit output = 0, regardless of clk.
REQ-018 rst going low mid-operation SHALL abort the division immediately with no done pulse.
REQ-019 After rst is released, the first start SHALL behave per REQ-013.

Configuration
REQ-020 The macro DIV_EARLY_TERM_EN SHALL control the early-termination check.
- Defined: CHECK evaluates a third priority condition, after overflow and before the normal path: if dividend_reg < divisor_reg (unsigned), assert special_zero and go to DONE.
- Undefined: special_zero is tied 0, and those operands take the full 67-cycle path.

Verification
REQ-021 divu 100 / 7: done in cycle 67; exactly 32 shift_signal cycles; sub_shift high in exactly 3 COMPARE cycles (counter 3, 2, 1).
REQ-022 div 0xFFFFFFEC (-20) / 3: the cycle-1 compute_sign shows flip_dividend = 1 and flip_divisor = 0; done in cycle 67.
REQ-023 div 55 / 0: divide_by_zero high in cycle 2 only, done in cycle 3, no compute_start.
REQ-024 div 0x80000000 / 0xFFFFFFFF gives overflow in cycle 2 and done in cycle 3; the same operands with divu give the normal path and done in cycle 67.
REQ-025 A start pulse in cycle 10 of a divu 9 / 2 operation is ignored (done only in cycle 67); rst driven low in cycle 30 forces all outputs to 0 and IDLE with no done pulse; the next start completes in 67 cycles.
REQ-026 divu 5 / 9: with DIV_EARLY_TERM_EN, special_zero is high in cycle 2 and done in cycle 3; without it, done in cycle 67 and special_zero never asserts.
